// File: rtl/mau_pkg.sv
// Shared types and sizing helpers for the line-fill responder.
package mau_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } mau_state_e;

    function automatic int unsigned mau_beats(input int unsigned line_w, input int unsigned mem_w);
        return line_w / mem_w;
    endfunction

    function automatic int unsigned mau_beat_idx_w(input int unsigned line_w, input int unsigned mem_w);
        return $clog2(line_w / mem_w);
    endfunction

    // Number of byte-offset bits inside a unit of w bits (a word or a line).
    function automatic int unsigned mau_byte_off_w(input int unsigned w);
        return $clog2(w / 8);
    endfunction

endpackage

// File: rtl/mau_line_buf.sv
// Line assembly register: one beat-wide slice written per response, cleared on reset.
module mau_line_buf
    import mau_pkg::*;
#(
    parameter int unsigned LINE_WIDTH     = 256,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    localparam int unsigned BEAT_IDX_W    = mau_beat_idx_w(LINE_WIDTH, MEM_DATA_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [BEAT_IDX_W-1:0]     wr_idx,
    input  logic [MEM_DATA_WIDTH-1:0] wr_data,
    output logic [LINE_WIDTH-1:0]     line
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (wr_en) begin
            line[wr_idx * MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= wr_data;
        end
    end

endmodule

// File: rtl/mau_line_fill.sv
// L1I line-fill responder: splits a line request into word reads and returns the assembled line.
// Optional critical-word-first wrap ordering is enabled with `define MAU_CWF_EN.
module mau_line_fill
    import mau_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINE_WIDTH     = 256,
    parameter int unsigned MEM_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mau_req_val,
    input  logic [ADDR_WIDTH-1:0]     mau_req_addr,
    output logic                      mau_req_ack,
    output logic [LINE_WIDTH-1:0]     mau_ack_data,
    output logic                      mem_req_val,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    input  logic                      mem_req_rdy,
    input  logic                      mem_rsp_val,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data
);

    localparam int unsigned BEATS      = mau_beats(LINE_WIDTH, MEM_DATA_WIDTH);
    localparam int unsigned BEAT_IDX_W = mau_beat_idx_w(LINE_WIDTH, MEM_DATA_WIDTH);
    localparam int unsigned CNT_W      = BEAT_IDX_W + 1;
    localparam int unsigned WORD_OFF_W = mau_byte_off_w(MEM_DATA_WIDTH);
    localparam int unsigned LINE_OFF_W = mau_byte_off_w(LINE_WIDTH);

    mau_state_e             state;
    logic [ADDR_WIDTH-1:0]  base;
    logic [CNT_W-1:0]       issue_cnt;
    logic [CNT_W-1:0]       rsp_cnt;

    logic [ADDR_WIDTH-1:0]  req_base;
    logic [BEAT_IDX_W-1:0]  first_beat;
    logic [BEAT_IDX_W-1:0]  next_beat;
    logic [BEAT_IDX_W-1:0]  rsp_beat;
    logic                   issue_fire;
    logic                   rsp_fire;
    logic                   last_issue;
    logic                   last_rsp;
    logic                   unused_addr_bits;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] line_base,
                                                        input logic [BEAT_IDX_W-1:0] beat);
        return line_base | (ADDR_WIDTH'(beat) << WORD_OFF_W);
    endfunction

    assign req_base         = {mau_req_addr[ADDR_WIDTH-1:LINE_OFF_W], LINE_OFF_W'(0)};
    assign unused_addr_bits = ^mau_req_addr[LINE_OFF_W-1:0];

    // Beat ordering: wrapped around the requested word, or linear from beat 0.
`ifdef MAU_CWF_EN
    logic [BEAT_IDX_W-1:0] start;

    assign first_beat = mau_req_addr[LINE_OFF_W-1:WORD_OFF_W];
    assign next_beat  = BEAT_IDX_W'(start + issue_cnt[BEAT_IDX_W-1:0] + BEAT_IDX_W'(1));
    assign rsp_beat   = BEAT_IDX_W'(start + rsp_cnt[BEAT_IDX_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start <= '0;
        end else if (state == IDLE && mau_req_val) begin
            start <= first_beat;
        end
    end
`else
    assign first_beat = '0;
    assign next_beat  = BEAT_IDX_W'(issue_cnt[BEAT_IDX_W-1:0] + BEAT_IDX_W'(1));
    assign rsp_beat   = rsp_cnt[BEAT_IDX_W-1:0];
`endif

    // Responses only count while a fill is in flight and never outrun issued beats.
    assign issue_fire = (state == REQ) && mem_req_val && mem_req_rdy;
    assign rsp_fire   = mem_rsp_val && (state == REQ || state == WAIT) && (rsp_cnt < issue_cnt);
    assign last_issue = issue_fire && (issue_cnt == CNT_W'(BEATS - 1));
    assign last_rsp   = rsp_fire && (rsp_cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            base         <= '0;
            issue_cnt    <= '0;
            rsp_cnt      <= '0;
            mau_req_ack  <= 1'b0;
            mem_req_val  <= 1'b0;
            mem_req_addr <= '0;
        end else begin
            mau_req_ack <= 1'b0;
            if (rsp_fire) begin
                rsp_cnt <= rsp_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (mau_req_val) begin
                        base         <= req_base;
                        issue_cnt    <= '0;
                        rsp_cnt      <= '0;
                        mem_req_val  <= 1'b1;
                        mem_req_addr <= beat_addr(req_base, first_beat);
                        state        <= REQ;
                    end
                end
                REQ: begin
                    // Address only advances on acceptance, so it holds through backpressure.
                    if (issue_fire) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                        if (last_issue) begin
                            mem_req_val <= 1'b0;
                        end else begin
                            mem_req_addr <= beat_addr(base, next_beat);
                        end
                    end
                    if (last_rsp) begin
                        mau_req_ack <= 1'b1;
                        state       <= ACK;
                    end else if (last_issue) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (last_rsp) begin
                        mau_req_ack <= 1'b1;
                        state       <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mau_line_buf #(
        .LINE_WIDTH     (LINE_WIDTH),
        .MEM_DATA_WIDTH (MEM_DATA_WIDTH)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rsp_fire),
        .wr_idx  (rsp_beat),
        .wr_data (mem_rsp_data),
        .line    (mau_ack_data)
    );

endmodule

// File: tb/tb_mau_line_fill.sv
// Directed bench for mau_line_fill: table of fills against a small in-order memory model.
module tb_mau_line_fill;

`ifdef MAU_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif
    localparam int BEATS = 8;

    logic         clk;
    logic         rst;
    logic         mau_req_val;
    logic [31:0]  mau_req_addr;
    logic         mau_req_ack;
    logic [255:0] mau_ack_data;
    logic         mem_req_val;
    logic [31:0]  mem_req_addr;
    logic         mem_req_rdy;
    logic         mem_rsp_val;
    logic [31:0]  mem_rsp_data;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] seed;
        int          stall_beat;
        int          stall_len;
        bit          burst;
        int          gap;
        bit          pre_reset;
        int          exp_ack;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vecs[5];

    mau_line_fill dut (
        .clk          (clk),
        .rst          (rst),
        .mau_req_val  (mau_req_val),
        .mau_req_addr (mau_req_addr),
        .mau_req_ack  (mau_req_ack),
        .mau_ack_data (mau_ack_data),
        .mem_req_val  (mem_req_val),
        .mem_req_addr (mem_req_addr),
        .mem_req_rdy  (mem_req_rdy),
        .mem_rsp_val  (mem_rsp_val),
        .mem_rsp_data (mem_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int vi, input int cyc,
                       input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s vec=%0d cyc=%0d actual=%0h required=%0h", name, vi, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] a, input int k);
        logic [31:0] base;
        int          start;
        base  = {a[31:5], 5'b0};
        start = CWF ? int'(a[4:2]) : 0;
        return base + 32'(((start + k) % BEATS) * 4);
    endfunction

    task automatic chk_reset_outputs(input int vi);
        chk("rst_ack", vi, 0, 256'(mau_req_ack), 256'(0));
        chk("rst_mem_val", vi, 0, 256'(mem_req_val), 256'(0));
        chk("rst_mem_addr", vi, 0, 256'(mem_req_addr), 256'(0));
        chk("rst_line", vi, 0, mau_ack_data, 256'(0));
    endtask

    // Abort a fill after beat 4 is accepted, then feed stray responses.
    task automatic reset_mid_fill(input int vi);
        @(posedge clk); #1;
        mau_req_val  = 1'b1;
        mau_req_addr = 32'h0000_3000;
        mem_req_rdy  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            mem_rsp_val  = (c >= 2 && c <= 5);
            mem_rsp_data = 32'h55 + 32'(c);
        end
        mem_rsp_val = 1'b0;
        mau_req_val = 1'b0;
        mem_req_rdy = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_outputs(vi);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mem_rsp_val  = 1'b1;
        mem_rsp_data = 32'hDEAD_BEEF;
        repeat (2) begin @(posedge clk); #1; end
        mem_rsp_val = 1'b0;
        chk("stray_line", vi, 0, mau_ack_data, 256'(0));
        chk("stray_mem_val", vi, 0, 256'(mem_req_val), 256'(0));
        chk("stray_ack", vi, 0, 256'(mau_req_ack), 256'(0));
    endtask

    // One fill; cycle 0 is the idle cycle that presents mau_req_val. Returns in the ack cycle.
    task automatic run_vec(input vec_t v, input int vi);
        logic [31:0] q_addr[$];
        int          q_due[$];
        logic [31:0] a;
        int          issued;
        int          stalled;
        int          ack_cyc;
        issued  = 0;
        stalled = 0;
        ack_cyc = -1;
        repeat (v.gap) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        for (int c = 0; c < 80 && ack_cyc < 0; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            chk("mau_req_ack", vi, c, 256'(mau_req_ack), 256'(c == v.exp_ack));
            chk("mem_req_val", vi, c, 256'(mem_req_val), 256'(c >= 1 && issued < BEATS));
            if (mem_req_val && issued < BEATS)
                chk("mem_req_addr", vi, c, 256'(mem_req_addr), 256'(exp_addr(v.addr, issued)));
            if (mau_req_ack) begin
                ack_cyc     = c;
                mau_req_val = 1'b0;
                mem_rsp_val = 1'b0;
                mem_req_rdy = 1'b0;
                for (int i = 0; i < BEATS; i++)
                    chk("line_word", vi, i, 256'(mau_ack_data[i*32 +: 32]), 256'(v.seed + 32'(i)));
                chk("beats_issued", vi, c, 256'(issued), 256'(BEATS));
                chk("rsp_pending", vi, c, 256'(q_addr.size()), 256'(0));
            end else begin
                mau_req_val  = 1'b1;
                mau_req_addr = v.addr;
                if (q_due.size() > 0 && q_due[0] <= c) begin
                    a = q_addr.pop_front();
                    void'(q_due.pop_front());
                    mem_rsp_val  = 1'b1;
                    mem_rsp_data = v.seed + 32'(a[4:2]);
                end else begin
                    mem_rsp_val  = 1'b0;
                    mem_rsp_data = 32'h0;
                end
                if (mem_req_val && issued == v.stall_beat && stalled < v.stall_len) begin
                    mem_req_rdy = 1'b0;
                    stalled++;
                end else begin
                    mem_req_rdy = 1'b1;
                end
                if (mem_req_val && mem_req_rdy && issued < BEATS) begin
                    if (issued == 0)
                        chk("first_addr", vi, c, 256'(mem_req_addr), 256'(v.exp_first));
                    q_addr.push_back(mem_req_addr);
                    q_due.push_back(v.burst ? 32'h4000_0000 : c + 1);
                    issued++;
                    if (v.burst && issued == BEATS)
                        foreach (q_due[i]) q_due[i] = c + 1;
                end
            end
        end
        if (ack_cyc < 0) begin
            compared++;
            mismatched++;
            $display("FAIL ack_timeout vec=%0d actual=none required=cycle %0d", vi, v.exp_ack);
            mau_req_val = 1'b0;
            mem_rsp_val = 1'b0;
            mem_req_rdy = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{addr: 32'h0000_1234, seed: 32'hA0, stall_beat: 99, stall_len: 0, burst: 1'b0,
                    gap: 2, pre_reset: 1'b0, exp_ack: 10,
                    exp_first: (CWF ? 32'h0000_1234 : 32'h0000_1220)};
        vecs[1] = '{addr: 32'h0000_1234, seed: 32'hA0, stall_beat: 2, stall_len: 3, burst: 1'b0,
                    gap: 2, pre_reset: 1'b0, exp_ack: 13,
                    exp_first: (CWF ? 32'h0000_1234 : 32'h0000_1220)};
        vecs[2] = '{addr: 32'h0000_4468, seed: 32'h10, stall_beat: 99, stall_len: 0, burst: 1'b1,
                    gap: 2, pre_reset: 1'b0, exp_ack: 17,
                    exp_first: (CWF ? 32'h0000_4468 : 32'h0000_4460)};
        vecs[3] = '{addr: 32'h0000_2000, seed: 32'h30, stall_beat: 99, stall_len: 0, burst: 1'b0,
                    gap: 0, pre_reset: 1'b0, exp_ack: 10,
                    exp_first: 32'h0000_2000};
        vecs[4] = '{addr: 32'h0000_51FC, seed: 32'h70, stall_beat: 6, stall_len: 1, burst: 1'b0,
                    gap: 1, pre_reset: 1'b1, exp_ack: 11,
                    exp_first: (CWF ? 32'h0000_51FC : 32'h0000_51E0)};

        rst          = 1'b1;
        mau_req_val  = 1'b0;
        mau_req_addr = 32'h0;
        mem_req_rdy  = 1'b0;
        mem_rsp_val  = 1'b0;
        mem_rsp_data = 32'h0;
        #12 chk_reset_outputs(-1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].pre_reset) reset_mid_fill(i);
            run_vec(vecs[i], i);
        end

        repeat (3) @(posedge clk);
        #1 chk("idle_ack", 99, 0, 256'(mau_req_ack), 256'(0));
        chk("idle_mem_val", 99, 0, 256'(mem_req_val), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
